// File: rtl/channel_tx_arbiter_pkg.sv
// Shared types and constants for the channel transmit arbiter.
package channel_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int unsigned ADDR_W          = 4;
  localparam logic [ADDR_W-1:0] PORT_NONE = 4'd0;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // Index width for a channel vector, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_tx_arbiter_if.sv
// Request/stream/grant bundle between the channels, the outbound mux and the arbiter.
interface channel_tx_arbiter_if
  import channel_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 6
);
  logic [NUM_CH-1:0] ch_req;
  logic              out_sof;
  logic              out_eof;
  logic              out_src_rdy;
  logic              out_dst_rdy;
  logic [ADDR_W-1:0] outport_addr;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              timeout;
  logic              framing_err;

  modport master (
    input  ch_req, out_sof, out_eof, out_src_rdy, out_dst_rdy,
    output outport_addr, grant, busy, timeout, framing_err
  );

  modport slave (
    output ch_req, out_sof, out_eof, out_src_rdy, out_dst_rdy,
    input  outport_addr, grant, busy, timeout, framing_err
  );
endinterface

// File: rtl/channel_tx_arbiter_rr_pick.sv
// Round-robin pick: first requesting channel searching upward (with wrap) from last_ptr+1.
module rr_pick
  import channel_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 6,
  localparam int unsigned IDX_W = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_ptr_i,
  output logic [IDX_W-1:0]  winner_o,
  output logic              any_o
);

  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    any_o    = |req_i;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = IDX_W'((int'(last_ptr_i) + i) % NUM_CH);
      if (req_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/channel_tx_arbiter.sv
// Frame-level round-robin arbiter for the outbound channel mux with idle-beat watchdog.
module channel_tx_arbiter
  import channel_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = 11
) (
  input logic                  clk,
  input logic                  rst,
  channel_tx_arbiter_if.master bus
);

  localparam int unsigned IDX_W     = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0]  pick_win;
  logic              pick_any;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              ferr_q, ferr_d;
  logic              beat, expire, release_now;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req_i      (bus.ch_req),
    .last_ptr_i (last_ptr_q),
    .winner_o   (pick_win),
    .any_o      (pick_any)
  );

  // A beat wins over a simultaneous watchdog expiry.
  assign beat        = (state_q == ST_XFER) && bus.out_src_rdy && bus.out_dst_rdy;
  assign expire      = (state_q == ST_XFER) && !beat && (wdog_q == WDOG_LAST);
  assign release_now = (beat && bus.out_eof) || expire;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any)    state_d = ST_XFER;
      ST_XFER: if (release_now) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_d      = win_q;
    last_ptr_d = last_ptr_q;
    wdog_d     = wdog_q;
    first_d    = first_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    busy_d     = (state_d == ST_XFER);
    timeout_d  = 1'b0;
    ferr_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_XFER) begin
        win_d            = pick_win;
        addr_d           = ADDR_W'(pick_win) + ADDR_W'(1);
        grant_d          = '0;
        grant_d[pick_win] = 1'b1;
        wdog_d           = '0;
        first_d          = 1'b1;
      end
    end else begin
      if (beat) begin
        wdog_d  = '0;
        first_d = 1'b0;
        ferr_d  = first_q ? !bus.out_sof : bus.out_sof;
      end else begin
        wdog_d = wdog_q + CNT_W'(1);
      end
      // Releasing channel drops to lowest priority whether it finished or stalled.
      if (release_now) begin
        addr_d     = PORT_NONE;
        grant_d    = '0;
        last_ptr_d = win_q;
        wdog_d     = '0;
        timeout_d  = expire;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      last_ptr_q <= IDX_W'(NUM_CH - 1);
      wdog_q     <= '0;
      first_q    <= 1'b0;
      addr_q     <= PORT_NONE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      last_ptr_q <= last_ptr_d;
      wdog_q     <= wdog_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.outport_addr = addr_q;
  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.timeout      = timeout_q;
  assign bus.framing_err  = ferr_q;

endmodule
